// File: rtl/tiger_msg_pad_if.sv
// Message word stream into the Tiger padder: valid/ready handshake with
// MSB-aligned byte count and end-of-message marker.
interface tiger_msg_pad_if;
  logic        valid;
  logic        ready;
  logic [63:0] data;
  logic        last;
  logic [3:0]  bytes;

  modport master (output valid, data, last, bytes, input ready);
  modport slave  (input valid, data, last, bytes, output ready);
endinterface

// File: rtl/tiger_msg_pad.sv
// Tiger message padder / block sequencer.
// Packs 64-bit message words into 512-bit blocks, appends the pad byte and
// the little-endian bit length, runs the external compression core once per
// block while chaining the 192-bit state, and presents the final digest.
// Optional build macro TIGER2_PAD_EN: pad byte 8'h80 (Tiger2) instead of
// 8'h01 (Tiger v1).
module tiger_msg_pad (
  input  logic           i_clk,
  input  logic           i_rst_n,
  tiger_msg_pad_if.slave msg,
  output logic           o_core_start,
  output logic [511:0]   o_core_data,
  output logic [191:0]   o_core_vin,
  input  logic [191:0]   i_core_vout,
  input  logic           i_core_done,
  output logic [191:0]   o_hash,
  output logic           o_hash_valid
);

  localparam logic [63:0] IV_A = 64'hEFCDAB8967452301;
  localparam logic [63:0] IV_B = 64'h1032547698BADCFE;
  localparam logic [63:0] IV_C = 64'h87E1B2C3B4A596F0;

`ifdef TIGER2_PAD_EN
  localparam logic [7:0] PAD_BYTE = 8'h80;
`else
  localparam logic [7:0] PAD_BYTE = 8'h01;
`endif

  typedef enum logic [2:0] {S_IDLE, S_FILL, S_RUN, S_PAD, S_OUT} state_t;
  // What to do once the current core run finishes.
  typedef enum logic [1:0] {NX_FILL, NX_PAD, NX_OUT} after_t;

  state_t         state_q, state_d;
  after_t         after_q;
  logic [511:0]   blk_q;
  logic [191:0]   vin_q;
  logic [191:0]   hash_q;
  logic [63:0]    len_q;
  logic [2:0]     widx_q;
  logic [6:0]     k_q;        // bytes in the final data block, 0..64
  logic           len_only_q; // next pad block carries only the length
  logic           start_q;
  logic           hash_valid_q;

  logic           ready;
  logic           word_ok;
  logic           accept;
  logic [3:0]     nbytes;
  logic [63:0]    bits;
  logic [63:0]    word_masked;

  function automatic logic [63:0] bswap64(input logic [63:0] v);
    logic [63:0] r;
    for (int i = 0; i < 8; i++) r[8*i +: 8] = v[8*(7-i) +: 8];
    return r;
  endfunction

  // Byte counts above 8 mean a full word; a zero-byte word only counts as an empty tail.
  assign nbytes  = (msg.bytes > 4'd8) ? 4'd8 : msg.bytes;
  assign bits    = {57'd0, nbytes, 3'd0};
  assign word_ok = msg.valid && ((nbytes != 4'd0) || msg.last);
  assign accept  = word_ok && ready;

  // Keep the valid leading bytes of the incoming word, zero the unused lanes.
  always_comb begin
    word_masked = '0;
    for (int b = 0; b < 8; b++) begin
      if (4'(b) < nbytes) word_masked[8*(7-b) +: 8] = msg.data[8*(7-b) +: 8];
    end
  end

  // Next-state and ready decode.
  always_comb begin
    // NOTE: every combinational output gets a default before the case so no latch is inferred.
    state_d = state_q;
    ready   = 1'b0;
    unique case (state_q)
      S_IDLE, S_FILL: begin
        ready = 1'b1;
        if (accept) begin
          if (msg.last)              state_d = S_PAD;
          else if (widx_q == 3'd7)   state_d = S_RUN;
          else                       state_d = S_FILL;
        end
      end
      S_RUN: begin
        if (i_core_done) begin
          unique case (after_q)
            NX_FILL: state_d = S_FILL;
            NX_PAD:  state_d = S_PAD;
            default: state_d = S_OUT;
          endcase
        end
      end
      S_PAD:   state_d = S_RUN;
      S_OUT:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge i_clk) begin
    // NOTE: sequential state is written with non-blocking assignments only.
    if (!i_rst_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Block buffer, length, chaining value and digest registers.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      // NOTE: the block buffer is a plain register (not RAM), so it is cleared here with everything else.
      blk_q        <= '0;
      vin_q        <= '0;
      hash_q       <= '0;
      len_q        <= '0;
      widx_q       <= '0;
      k_q          <= '0;
      len_only_q   <= 1'b0;
      after_q      <= NX_OUT;
      start_q      <= 1'b0;
      hash_valid_q <= 1'b0;
    end else begin
      start_q      <= (state_d == S_RUN) && (state_q != S_RUN);
      hash_valid_q <= 1'b0;
      unique case (state_q)
        S_IDLE, S_FILL: begin
          if (accept) begin
            blk_q[{~widx_q, 6'd0} +: 64] <= word_masked;
            widx_q <= widx_q + 3'd1;
            k_q    <= {1'b0, widx_q, 3'd0} + {3'd0, nbytes};
            if (state_q == S_IDLE) begin
              vin_q <= {IV_A, IV_B, IV_C};
              len_q <= bits;
            end else begin
              len_q <= len_q + bits;
            end
            if (!msg.last) after_q <= NX_FILL;
          end
        end
        S_RUN: begin
          if (i_core_done) begin
            vin_q  <= i_core_vout;
            blk_q  <= '0;
            widx_q <= '0;
          end
        end
        S_PAD: begin
          if (len_only_q) begin
            blk_q[63:0] <= bswap64(len_q);
            len_only_q  <= 1'b0;
            after_q     <= NX_OUT;
          end else if (k_q <= 7'd55) begin
            blk_q[{~k_q[5:0], 3'd0} +: 8] <= PAD_BYTE;
            blk_q[63:0] <= bswap64(len_q);
            after_q     <= NX_OUT;
          end else if (k_q <= 7'd63) begin
            // Pad byte fits but the length does not: a second, length-only block follows.
            blk_q[{~k_q[5:0], 3'd0} +: 8] <= PAD_BYTE;
            len_only_q  <= 1'b1;
            after_q     <= NX_PAD;
          end else begin
            // Full data block goes as-is; the follow-up block pads from byte 0.
            k_q     <= '0;
            after_q <= NX_PAD;
          end
        end
        S_OUT: begin
          hash_q       <= vin_q;
          hash_valid_q <= 1'b1;
          k_q          <= '0;
          len_only_q   <= 1'b0;
          after_q      <= NX_OUT;
        end
        default: ;
      endcase
    end
  end

  assign msg.ready    = ready && i_rst_n;
  assign o_core_start = start_q;
  assign o_core_data  = blk_q;
  assign o_core_vin   = vin_q;
  assign o_hash       = hash_q;
  assign o_hash_valid = hash_valid_q;

endmodule

// File: tb/tb_tiger_msg_pad.sv
// Testbench for tiger_msg_pad. A stand-in compression core (fixed latency,
// cheap mixing function) replaces Tiger; a reference padder in the bench
// predicts every block, chaining value, run count and digest.
module tb_tiger_msg_pad;

  localparam logic [191:0] IV = {64'hEFCDAB8967452301, 64'h1032547698BADCFE, 64'h87E1B2C3B4A596F0};
`ifdef TIGER2_PAD_EN
  localparam logic [7:0] PAD_BYTE = 8'h80;
`else
  localparam logic [7:0] PAD_BYTE = 8'h01;
`endif
  localparam int CORE_LAT = 4;

  typedef struct {
    logic [511:0] blk;
    logic [191:0] vin;
  } blk_exp_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         core_start;
  logic [511:0] core_data;
  logic [191:0] core_vin;
  logic [191:0] core_vout;
  logic         core_done;
  logic [191:0] hash;
  logic         hash_valid;

  tiger_msg_pad_if msg ();

  tiger_msg_pad dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .msg          (msg),
    .o_core_start (core_start),
    .o_core_data  (core_data),
    .o_core_vin   (core_vin),
    .i_core_vout  (core_vout),
    .i_core_done  (core_done),
    .o_hash       (hash),
    .o_hash_valid (hash_valid)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Stand-in core mixing function.
  function automatic logic [191:0] fake_core(input logic [191:0] v, input logic [511:0] d);
    logic [191:0] a;
    a = v;
    for (int i = 0; i < 8; i++) begin
      a = {a[130:0], a[191:131]} ^ {d[64*i +: 64], d[64*i +: 64] ^ 64'h9E3779B97F4A7C15, ~d[64*i +: 64]};
      a[63:0] = a[63:0] + a[191:128];
    end
    return a;
  endfunction

  // Stand-in core: captures inputs on start, answers CORE_LAT cycles later.
  int           core_cnt;
  logic [191:0] cap_v;
  logic [511:0] cap_d;
  always @(posedge clk) begin
    if (!rst_n) begin
      core_cnt  <= 0;
      core_done <= 1'b0;
      core_vout <= '0;
    end else begin
      core_done <= 1'b0;
      if (core_start) begin
        core_cnt <= CORE_LAT;
        cap_v    <= core_vin;
        cap_d    <= core_data;
      end else if (core_cnt != 0) begin
        core_cnt <= core_cnt - 1;
        if (core_cnt == 1) begin
          core_done <= 1'b1;
          core_vout <= fake_core(cap_v, cap_d);
        end
      end
    end
  end

  // Scoreboard queues.
  logic [7:0]   msg_b[$];
  blk_exp_t     exp_blk_q[$];
  logic [191:0] exp_hash_q[$];
  int           exp_runs_q[$];

  // Reference Tiger padding and chaining over the message in msg_b.
  task automatic model_msg();
    logic [7:0]   p[$];
    logic [63:0]  nbits;
    logic [191:0] v;
    logic [511:0] blk;
    int           nblk;
    p = msg_b;
    nbits = 64'(msg_b.size()) << 3;
    p.push_back(PAD_BYTE);
    while (p.size() % 64 != 56) p.push_back(8'h00);
    for (int i = 0; i < 8; i++) p.push_back(nbits[8*i +: 8]);
    nblk = p.size() / 64;
    v = IV;
    for (int b = 0; b < nblk; b++) begin
      for (int j = 0; j < 64; j++) blk[511-8*j -: 8] = p[64*b+j];
      exp_blk_q.push_back('{blk: blk, vin: v});
      v = fake_core(v, blk);
    end
    exp_hash_q.push_back(v);
    exp_runs_q.push_back(nblk);
  endtask

  // Monitor: compares blocks at each start, digests at each hash pulse.
  logic         busy = 1'b0;
  logic [511:0] held;
  logic [511:0] last_blk;
  logic [191:0] last_hash;
  int           starts = 0;
  int           stab_err = 0;
  int           rdy_err = 0;
  always @(negedge clk) begin
    blk_exp_t e;
    logic [191:0] eh;
    int er;
    if (!rst_n) begin
      busy   = 1'b0;
      starts = 0;
    end else begin
      if (core_start) begin
        if (exp_blk_q.size() == 0) check("unexpected_start", 1, 0);
        else begin
          e = exp_blk_q.pop_front();
          check("core_data", core_data, e.blk);
          check("core_vin", core_vin, e.vin);
        end
        held     = core_data;
        last_blk = core_data;
        busy     = 1'b1;
        starts++;
      end else if (busy && core_data !== held) begin
        stab_err++;
      end
      if (busy && msg.ready) rdy_err++;
      if (core_done) busy = 1'b0;
      if (hash_valid) begin
        if (exp_hash_q.size() == 0) check("unexpected_hash", 1, 0);
        else begin
          eh = exp_hash_q.pop_front();
          er = exp_runs_q.pop_front();
          check("hash", hash, eh);
          check("runs", starts, er);
          last_hash = eh;
        end
        starts = 0;
      end
    end
  end

  task automatic drive_word(input logic [63:0] d, input logic [3:0] b, input logic l);
    int budget;
    budget = 0;
    @(negedge clk);
    msg.valid = 1'b1;
    msg.data  = d;
    msg.bytes = b;
    msg.last  = l;
    while (!msg.ready && budget < 2000) begin
      @(negedge clk);
      budget++;
    end
    if (!msg.ready) check("ready_timeout", 0, 1);
  endtask

  // mode 0: plain; 1: full words then empty tail word; 2: zero-byte word inserted mid-message;
  // 3: final full word claims 15 bytes.
  task automatic send_msg(input int mode);
    int n, nw, bl;
    logic [63:0] d;
    logic [3:0]  bf;
    logic        lst;
    n = msg_b.size();
    model_msg();
    nw = (n == 0) ? 1 : (n + 7) / 8;
    for (int w = 0; w < nw; w++) begin
      if (mode == 2 && w == nw / 2) drive_word(64'hDEADBEEFCAFEF00D, 4'd0, 1'b0);
      bl = n - 8 * w;
      if (bl > 8) bl = 8;
      for (int b = 0; b < 8; b++) d[63-8*b -: 8] = (b < bl) ? msg_b[8*w+b] : 8'hA5;
      lst = (w == nw - 1) && (mode != 1);
      bf  = 4'(bl);
      if (mode == 3 && lst && bl == 8) bf = 4'd15;
      drive_word(d, bf, lst);
    end
    if (mode == 1) drive_word(64'h0123456789ABCDEF, 4'd0, 1'b1);
    @(negedge clk);
    msg.valid = 1'b0;
  endtask

  task automatic fill_rand(input int n);
    msg_b.delete();
    for (int i = 0; i < n; i++) msg_b.push_back(8'($urandom_range(0, 255)));
  endtask

  task automatic wait_done();
    int budget;
    budget = 0;
    while (exp_hash_q.size() != 0 && budget < 3000) begin
      @(negedge clk);
      budget++;
    end
    if (exp_hash_q.size() != 0) begin
      check("done_timeout", exp_hash_q.size(), 0);
      exp_hash_q.delete();
      exp_runs_q.delete();
      exp_blk_q.delete();
    end
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int budget;
    rst_n     = 1'b0;
    msg.valid = 1'b0;
    msg.data  = '0;
    msg.bytes = '0;
    msg.last  = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ready", msg.ready, 0);
    check("rst_hash_valid", hash_valid, 0);
    check("rst_hash", hash, 0);
    check("rst_start", core_start, 0);
    check("rst_core_data", core_data, 0);
    check("rst_core_vin", core_vin, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_ready", msg.ready, 1);

    // Empty message: one run.
    msg_b.delete();
    send_msg(0);
    wait_done();
    check("empty_hold", hash, last_hash);

    // "abc"
    msg_b.delete();
    msg_b.push_back(8'h61); msg_b.push_back(8'h62); msg_b.push_back(8'h63);
    send_msg(0);
    wait_done();

    fill_rand(55); send_msg(0); wait_done();

    fill_rand(56); send_msg(0); wait_done();
    check("len_blk_slot7", last_blk[63:0], 64'hC001000000000000);
    check("len_blk_zero", last_blk[511:64], 0);

    fill_rand(63); send_msg(0); wait_done();

    fill_rand(64); send_msg(0); wait_done();
    check("k64_pad_byte0", last_blk[511:504], PAD_BYTE);

    fill_rand(64); send_msg(1); wait_done();
    fill_rand(130); send_msg(2); wait_done();
    fill_rand(16); send_msg(3); wait_done();
    fill_rand(200); send_msg(0); wait_done();

    // Reset while a core run is in flight.
    fill_rand(64);
    send_msg(0);
    budget = 0;
    while (!busy && budget < 200) begin
      @(negedge clk);
      budget++;
    end
    check("busy_before_reset", busy, 1);
    rst_n = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("midrst_hash_valid", hash_valid, 0);
      check("midrst_ready", msg.ready, 0);
      check("midrst_start", core_start, 0);
    end
    exp_blk_q.delete();
    exp_hash_q.delete();
    exp_runs_q.delete();
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_ready", msg.ready, 1);
    msg_b.delete();
    send_msg(0);
    wait_done();
    repeat (5) @(negedge clk);
    check("hash_held", hash, last_hash);

    check("data_stable_in_run", stab_err, 0);
    check("ready_low_in_run", rdy_err, 0);
    check("leftover_blocks", exp_blk_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
